// File: rtl/rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rtc_bus_sequencer
// Purpose  : Arbitrates up to four requesters onto the RTC multiplexed AD bus
//            and generates the full address-phase / data-phase strobe
//            sequence for one single-register read or write per grant.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_bus_sequencer #(
  parameter int TPH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  rw,
  input  logic [3:0]  lock,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  ADin,
  output logic [7:0]  ADout,
  output logic        Pullup,
  output logic        ad,
  output logic        cs,
  output logic        wr,
  output logic        rd,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [7:0]  rdata,
  output logic        busy
);

  localparam int              C_CNT_W = $clog2(TPH + 1);
  localparam logic [C_CNT_W-1:0] C_LOAD = C_CNT_W'(TPH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_A_SET = 3'd1,
    S_A_STB = 3'd2,
    S_A_HLD = 3'd3,
    S_D_SET = 3'd4,
    S_D_STB = 3'd5,
    S_D_HLD = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]           owner_q, owner_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 rw_q, rw_d;
  logic [7:0]           rlatch_q, rlatch_d;
  logic [7:0]           rdata_q, rdata_d;

  logic [1:0]           prio_sel;
  logic                 tc;
  logic                 take;
  logic [1:0]           src;

  // Phase counter counts down from TPH-1; zero is the last cycle of a sub-phase.
  assign tc    = (cnt_q == '0);
  assign rdata = rdata_q;

  // Fixed-priority pick: lowest requesting index wins.
  always_comb begin
    prio_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) prio_sel = 2'(i);
    end
  end

  // State and transaction registers; reset returns the bus to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= C_LOAD;
      owner_q  <= 2'd0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rw_q     <= 1'b0;
      rlatch_q <= 8'h00;
      rdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      rlatch_q <= rlatch_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state, phase timing, transaction latching and bus outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = C_LOAD;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    rlatch_d = rlatch_q;
    rdata_d  = rdata_q;
    take     = 1'b0;
    src      = owner_q;

    ad     = 1'b1;
    cs     = 1'b1;
    wr     = 1'b1;
    rd     = 1'b1;
    ADout  = 8'h00;
    Pullup = 1'b0;
    done   = 4'b0000;
    grant  = (state_q == S_IDLE) ? 4'b0000 : (4'b0001 << owner_q);
    busy   = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_A_SET;
          take    = 1'b1;
          src     = prio_sel;
        end
      end
      S_A_SET, S_A_STB, S_A_HLD: begin
        cs     = 1'b0;
        ad     = 1'b0;
        ADout  = addr_q;
        Pullup = 1'b1;
        wr     = (state_q != S_A_STB);
        if (tc) begin
          case (state_q)
            S_A_SET: state_d = S_A_STB;
            S_A_STB: state_d = S_A_HLD;
            default: state_d = S_D_SET;
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_D_SET, S_D_STB, S_D_HLD: begin
        cs     = 1'b0;
        ad     = 1'b1;
        ADout  = wdata_q;
        Pullup = ~rw_q;
        if (state_q == S_D_STB) begin
          wr = rw_q;
          rd = ~rw_q;
        end
        if (tc) begin
          case (state_q)
            S_D_SET: state_d = S_D_STB;
            S_D_STB: begin
              state_d  = S_D_HLD;
              rlatch_d = ADin;   // sample read data while rd is still low
            end
            default: begin
              state_d = S_DONE;
              if (rw_q) rdata_d = rlatch_q;
            end
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        done = 4'b0001 << owner_q;
        // A locked owner keeps the bus; no arbitration against others.
        if (lock[owner_q] && req[owner_q]) begin
          state_d = S_A_SET;
          take    = 1'b1;
          src     = owner_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      owner_d = src;
      addr_d  = req_addr[{src, 3'b000} +: 8];
      wdata_d = req_wdata[{src, 3'b000} +: 8];
      rw_d    = rw[src];
    end
  end

endmodule
`default_nettype wire

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Arbitrated bus-cycle sequencer for the external RTC's multiplexed address/data bus. It accepts single-register read/write requests from up to four requesters, such as the init, data-extract, hour/date store and chrono store engines. It grants the bus to one requester at a time and generates the complete address-phase/data-phase strobe sequence itself. It replaces a purely selected control mux: requesters supply only address, data and direction, and this block owns all bus timing.

## Interface
- TPH, 4: cycles per bus sub-phase; legal range 1–255.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  4  per-requester transaction request; level-sensitive.
- rw  in  4  per-requester direction: 1 = read, 0 = write.
- lock  in  4  per-requester burst hold: keep ownership after the current transaction.
- req_addr  in  32  four 8-bit register addresses; requester i uses [8i+7:8i].
- req_wdata  in  32  four 8-bit write data values, same packing as req_addr.
- ADin  in  8  AD bus value read back from the RTC.
- ADout  out  8  AD bus value driven to the RTC.
- Pullup  out  1  1 = FPGA drives the AD bus; 0 = AD pins tri-stated.
- ad, cs, wr, rd  out  1 each  RTC strobes; cs, wr and rd are active-low; ad=0 marks the address phase, ad=1 the data phase.
- grant  out  4  one-hot owner of the bus; all zeros when idle.
- done  out  4  one-cycle pulse to the owner at transaction end.
- rdata  out  8  last read value; valid from the cycle done pulses and held until the next read completes.
- busy  out  1  1 from grant until the cycle after DONE.

## Operation
- Reset values: ad=cs=wr=rd=1, ADout=0x00, Pullup=0, grant=0, done=0, rdata=0x00, busy=0. The FSM enters IDLE.
- FSM states and outputs:
  - IDLE: all strobes high.
  - A_SET: cs=0, ad=0, wr=1, ADout=addr, Pullup=1.
  - A_STB: as A_SET, but wr=0.
  - A_HLD: as A_SET, wr=1.
  - D_SET: cs=0, ad=1, ADout=wdata; Pullup=~rw.
  - D_STB: as D_SET, plus wr=0 for a write or rd=0 for a read.
  - D_HLD: as D_SET, strobes high.
  - DONE: cs=1, ad=1, Pullup=0, done[owner]=1.
- Each of the six A_*/D_* states lasts exactly TPH cycles, timed by a phase counter. The counter is ceil(log2(TPH+1)) bits wide, reloads on every state entry, and advances on terminal count.
- Arbitration: fixed priority, lowest index wins. Requests are sampled only in IDLE. The grant latches owner, address, data and direction, so later changes to these inputs are ignored until DONE.
- In IDLE with any req bit set, the next state is A_SET and grant updates on the same edge.
- Read capture: on the last cycle of D_STB, ADin is registered into an internal latch. rdata updates from that latch on entry to DONE.
- Leaving DONE:
  - If lock[owner]=1 and req[owner]=1, go directly to A_SET with the same owner and fresh address/data. No arbitration occurs, even against a higher-priority request.
  - Otherwise clear grant and go to IDLE.
- Dropping req mid-transaction does not abort it; the transaction completes and done still pulses.
- rst asserted in any state: on that edge, go to IDLE with all outputs at their reset values. done is not pulsed and rdata is cleared.

## Timing
- Request to grant: request seen at edge k gives grant and cs=0 in cycle k+1. Latency is 1 cycle.
- Transaction length from grant to done is 6·TPH cycles. done is high in cycle 6·TPH+1 after grant.
- Back-to-back unlocked transactions: one IDLE cycle between DONE and the next A_SET, giving a period of 6·TPH+2 cycles.
- Locked burst period: 6·TPH+1 cycles.
- ADout and Pullup change only at state boundaries, never during a strobe-low cycle.
- With TPH=1, every state is exactly one cycle; no state may be skipped.

## Test plan
- Single write, TPH=2, req[2]=1, addr 0x21, data 0x45:
  - grant=0100 next cycle.
  - ADout=0x21 with ad=0 for 6 cycles; wr low in cycles 3–4.
  - ADout=0x45 with ad=1 for 6 cycles; wr low in cycles 9–10.
  - done[2] in cycle 13; cs=1 and Pullup=0 in cycle 13.
- Read, TPH=2, req[1]=1, rw[1]=1, addr 0x42, ADin=0x37 during D_STB:
  - Pullup=0 throughout the data phase; rd low in cycles 9–10.
  - rdata=0x37 when done[1] pulses.
- Simultaneous req=1001:
  - requester 0 is served first.
  - requester 3 is granted in the cycle after IDLE, 14 cycles after the first grant when TPH=2.
- Locked burst, TPH=1:
  - req[3]=1 and lock[3]=1 for three transactions while req[0] rises after the first.
  - Three consecutive requester-3 transactions, 7 cycles each, with no IDLE between them.
  - req[0] is granted only after lock[3] drops.
- Reset mid-D_STB of a write: the next cycle has all strobes high, grant=0, no done pulse, and the bus idle.
- TPH=1, req toggled to 0 after the grant: the transaction still completes in 6 cycles with a done pulse, then IDLE with grant=0.
